// File: rtl/sysray_drain.sv
// sysray_drain: deskews systolic psum columns into rows, accumulates K-tiles per group, buffers finished rows in a FIFO (optional saturation via SYSRAY_DRAIN_SAT_EN)
module sysray_drain #(
  parameter int N          = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_valid_i,
  input  logic                   issue_last_i,
  output logic                   issue_ready_o,
  input  logic [N*ACC_WIDTH-1:0] psum_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [N*ACC_WIDTH-1:0] out_data_o,
  output logic                   err_o
);
  localparam int S  = LAT + N - 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(S + FIFO_DEPTH + 1);

  logic [S-1:0]           tv, tl;
  logic [ACC_WIDTH-1:0]   row [N];
  logic [ACC_WIDTH-1:0]   acc [N];
  logic [ACC_WIDTH-1:0]   sum [N];
  logic [N-1:0]           clamp;
  logic                   first, strobe, row_last, push, pop, drop, full, sat_err;
  logic [AW:0]            count, count_n;
  logic [AW-1:0]          wp, rp, rp_n;
  logic [N*ACC_WIDTH-1:0] wdata, head_n;
  logic [N*ACC_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]          pend;

  // tag pipe: stage k (bit k-1) holds the issue made k cycles ago
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tv <= '0;
      tl <= '0;
    end else begin
      tv <= S'({tv, issue_valid_i});
      tl <= S'({tl, issue_valid_i & issue_last_i});
    end

  assign strobe   = tv[S-1];
  assign row_last = tl[S-1];

  for (genvar c = 0; c < N; c++) begin : g_col
    logic [ACC_WIDTH-1:0] base;
    if (c == N-1) begin : g_live
      assign row[c] = psum_i[c*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] ch [N-1-c];
      // capture column c when its tag is at stage LAT+c, then delay it to the row strobe
      always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
          for (int j = 0; j < N-1-c; j++) ch[j] <= '0;
        end else begin
          if (tv[LAT+c-1]) ch[0] <= psum_i[c*ACC_WIDTH +: ACC_WIDTH];
          for (int j = 1; j < N-1-c; j++) ch[j] <= ch[j-1];
        end
      assign row[c] = ch[N-2-c];
    end
    assign base = first ? '0 : acc[c];
`ifdef SYSRAY_DRAIN_SAT_EN
    logic [ACC_WIDTH:0] wide;
    assign wide     = {base[ACC_WIDTH-1], base} + {row[c][ACC_WIDTH-1], row[c]};
    assign clamp[c] = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    assign sum[c]   = clamp[c] ? {wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}} : wide[ACC_WIDTH-1:0];
`else
    assign clamp[c] = 1'b0;
    assign sum[c]   = base + row[c];
`endif
    assign wdata[c*ACC_WIDTH +: ACC_WIDTH] = sum[c];
  end

  assign sat_err     = |clamp;
  assign out_valid_o = count != '0;
  assign full        = count == (AW+1)'(FIFO_DEPTH);
  assign pop         = out_valid_o & out_ready_i;
  assign push        = strobe & row_last & (~full | pop);
  assign drop        = strobe & row_last & full & ~pop;
  assign count_n     = count + (AW+1)'(push) - (AW+1)'(pop);
  assign rp_n        = rp + AW'(pop);
  assign head_n      = (push && wp == rp_n) ? wdata : mem[rp_n];

  // credit: rows already in flight toward the FIFO count against its free space
  always_comb begin
    pend = '0;
    for (int k = 0; k < S; k++) pend = pend + CW'(tl[k]);
  end

  assign issue_ready_o = (CW'(count) + pend) < CW'(FIFO_DEPTH);

  // accumulator, group-start flag and sticky error
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int c = 0; c < N; c++) acc[c] <= '0;
      first <= 1'b1;
      err_o <= 1'b0;
    end else begin
      if (strobe) begin
        for (int c = 0; c < N; c++) acc[c] <= sum[c];
        first <= row_last;
      end
      err_o <= err_o | drop | (strobe & sat_err);
    end

  // FIFO storage holds no reset state; validity comes from the count
  always_ff @(posedge clk_i)
    if (push) mem[wp] <= wdata;

  // FIFO pointers, count and registered head (holds last popped row when empty)
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      out_data_o <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      rp    <= rp_n;
      count <= count_n;
      if (count_n != '0 && (pop || count == '0)) out_data_o <= head_n;
    end
endmodule

// File: tb/tb_sysray_drain.sv
// tb_sysray_drain: randomized and directed checks of sysray_drain against a cycle-level queue model
module tb_sysray_drain;
  localparam int N = 4, W = 32, LAT = 4, D = 4, S = LAT + N - 1, MAXC = 4096;

  logic           clk = 0, rst_ni = 1, issue_valid_i = 0, issue_last_i = 0, out_ready_i = 0;
  logic [N*W-1:0] psum_i = '0;
  logic           issue_ready_o, out_valid_o, err_o;
  logic [N*W-1:0] out_data_o;

  always #5 clk = ~clk;

  sysray_drain #(.N(N), .ACC_WIDTH(W), .LAT(LAT), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .issue_valid_i(issue_valid_i), .issue_last_i(issue_last_i),
    .issue_ready_o(issue_ready_o), .psum_i(psum_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .err_o(err_o));

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // model: per-cycle issue history, expected FIFO contents as a queue
  bit             hv [MAXC];
  bit             hl [MAXC];
  logic [N*W-1:0] hrow [MAXC];
  logic [N*W-1:0] q [$];
  logic [N*W-1:0] last_pop = '0;
  logic [W-1:0]   macc [N];
  bit             mfirst = 1, merr = 0;
  int             n = 0;

  function automatic int pend_now();
    int p = 0;
    for (int m = n - S; m < n; m++) if (m >= 0 && hv[m] && hl[m]) p++;
    return p;
  endfunction

  function automatic bit model_ready();
    return (q.size() + pend_now()) < D;
  endfunction

  function automatic logic [N*W-1:0] rowv(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [N*W-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input bit v, input bit l, input bit r, input logic [N*W-1:0] row);
    logic [N*W-1:0] sr;
    longint a, b, s;
    int m;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget got=%0d exp<%0d", n, MAXC);
      $fatal(1, "history exhausted");
    end
    @(negedge clk);
    check("out_valid", out_valid_o, q.size() != 0);
    check("out_data", out_data_o, q.size() != 0 ? q[0] : last_pop);
    check("issue_ready", issue_ready_o, model_ready());
    check("err", err_o, merr);
    issue_valid_i = v;
    issue_last_i  = l;
    out_ready_i   = r;
    hv[n]   = v;
    hl[n]   = v & l;
    hrow[n] = row;
    for (int c = 0; c < N; c++) begin
      m = n - LAT - c;
      psum_i[c*W +: W] = (m >= 0 && hv[m]) ? hrow[m][c*W +: W] : $urandom;
    end
    if (q.size() != 0 && r) last_pop = q.pop_front();
    m = n - S;
    if (m >= 0 && hv[m]) begin
      for (int c = 0; c < N; c++) begin
        a = mfirst ? 0 : longint'($signed(macc[c]));
        b = longint'($signed(hrow[m][c*W +: W]));
        s = a + b;
`ifdef SYSRAY_DRAIN_SAT_EN
        if (s > 64'sh7FFF_FFFF) begin s = 64'sh7FFF_FFFF; merr = 1; end
        if (s < -64'sh8000_0000) begin s = -64'sh8000_0000; merr = 1; end
`endif
        macc[c] = s[W-1:0];
        sr[c*W +: W] = s[W-1:0];
      end
      if (hl[m]) begin
        if (q.size() < D) q.push_back(sr);
        else merr = 1;
      end
      mfirst = hl[m];
    end
    n++;
  endtask

  task automatic idle(input int k, input bit r);
    for (int i = 0; i < k; i++) step(0, 0, r, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 0;
    issue_valid_i = 0;
    issue_last_i = 0;
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_ready", issue_ready_o, 1);
    check("rst_err", err_o, 0);
    @(negedge clk);
    rst_ni = 1;
    q.delete();
    last_pop = '0;
    mfirst = 1;
    merr = 0;
    for (int c = 0; c < N; c++) macc[c] = '0;
    for (int m = 0; m < n + 2 && m < MAXC; m++) begin hv[m] = 0; hl[m] = 0; end
    n += 2;
  endtask

  initial begin
    logic [N*W-1:0] r0;
    int issued;
    for (int c = 0; c < N; c++) macc[c] = '0;
    #2 rst_ni = 0;
    #1;
    check("init_valid", out_valid_o, 0);
    check("init_data", out_data_o, 0);
    check("init_ready", issue_ready_o, 1);
    check("init_err", err_o, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1;

    // single-tile group: 8-cycle latency
    step(1, 1, 1, rowv(1, 2, 3, 4));
    idle(7, 1);
    check("t1_early", out_valid_o, 0);
    idle(1, 1);
    check("t1_valid", out_valid_o, 1);
    check("t1_data", out_data_o, rowv(1, 2, 3, 4));
    idle(3, 1);

    // three-tile accumulation
    step(1, 0, 1, rowv(10, 20, 30, 40));
    step(1, 0, 1, rowv(10, 20, 30, 40));
    step(1, 1, 1, rowv(10, 20, 30, 40));
    idle(7, 1);
    check("t2_early", out_valid_o, 0);
    idle(1, 1);
    check("t2_valid", out_valid_o, 1);
    check("t2_data", out_data_o, rowv(30, 60, 90, 120));
    idle(3, 1);

    // credit exhaustion with stalled consumer, then drain in order
    r0 = rnd_row();
    step(1, 1, 0, r0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, rnd_row());
    idle(1, 0);
    check("t3_ready_low", issue_ready_o, 0);
    idle(10, 0);
    check("t3_full_valid", out_valid_o, 1);
    check("t3_head", out_data_o, r0);
    issued = 0;
    for (int i = 0; i < 16; i++) begin
      if (issued < 4 && model_ready()) begin step(1, 1, 1, rnd_row()); issued++; end
      else step(0, 0, 1, '0);
    end
    idle(12, 1);

    // protocol-violating issue with FIFO full: dropped, sticky error
    r0 = rnd_row();
    step(1, 1, 0, r0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, rnd_row());
    idle(10, 0);
    step(1, 1, 0, rnd_row());
    idle(10, 0);
    check("t4_err", err_o, 1);
    check("t4_head_intact", out_data_o, r0);
    idle(12, 1);
    check("t4_err_sticky", err_o, 1);
    do_reset();

    // overflow behaviour on column 0
    step(1, 0, 1, rowv(32'h7FFF_FFFF, 0, 0, 0));
    step(1, 1, 1, rowv(32'h7FFF_FFFF, 0, 0, 0));
    idle(8, 1);
`ifdef SYSRAY_DRAIN_SAT_EN
    check("t5_data", out_data_o, rowv(32'h7FFF_FFFF, 0, 0, 0));
    check("t5_err", err_o, 1);
`else
    check("t5_data", out_data_o, rowv(32'hFFFF_FFFE, 0, 0, 0));
    check("t5_err", err_o, 0);
`endif
    idle(2, 1);
    do_reset();

    // reset with one FIFO entry and tiles in flight
    step(1, 1, 0, rnd_row());
    idle(8, 0);
    check("t6_entry", out_valid_o, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, rnd_row());
    idle(5, 0);
    do_reset();
    idle(12, 1);
    step(1, 1, 1, rowv(5, 6, 7, 8));
    idle(8, 1);
    check("t6_fresh", out_data_o, rowv(5, 6, 7, 8));
    idle(2, 1);

    // randomized traffic, last-issues only when credit allows
    for (int i = 0; i < 1500; i++) begin
      bit v, l;
      v = ($urandom % 4) != 0;
      l = v && (($urandom % 3) == 0) && model_ready();
      step(v, l, ($urandom % 3) != 0, ($urandom % 2) ? rnd_row() : rowv($urandom % 1000, $urandom % 1000, $urandom % 1000, $urandom % 1000));
    end
    idle(20, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
